dds_ook_ctrl: RTL and testbench

Frame controller for the OOK DDS transmitter. It accepts one data byte and one 32-bit tuning word per handshake. It serialises each byte into a timed OOK frame (start mark, 8 data bits, stop space) on `ook_data`, and presents the carrier tuning word on `freq_word`. It sits between the byte source (UART receive path or host logic) and the DDS phase accumulator and OOK gate. It is the only writer of the DDS frequency word and the only driver of the OOK keying line.

---
 rtl/dds_ook_ctrl.sv | 124 ++++++++++++
 tb/tb_dds_ook_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dds_ook_ctrl.sv
// OOK frame serialiser (start mark, 8 data bits MSB first, stop space) and DDS tuning-word owner.
// Frame starts the cycle after acceptance and lasts 10*P cycles. A byte or config is accepted only in IDLE, and config takes priority over a byte.
module dds_ook_ctrl #(
  parameter logic [31:0] RESET_FREQ = 32'h0100_0000,
  parameter int          PERIOD_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  input  logic [31:0]         cfg_word,
  output logic                cfg_ready,
  input  logic                tx_valid,
  input  logic [7:0]          tx_data,
  output logic                tx_ready,
  input  logic [PERIOD_W-1:0] bit_period,
  output logic                ook_data,
  output logic [31:0]         freq_word,
  output logic                busy,
  output logic                frame_done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [PERIOD_W-1:0] ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

  state_t              state, state_nxt;
  logic [PERIOD_W-1:0] per_cnt, per_nxt;
  logic [PERIOD_W-1:0] p_lat, p_nxt;
  logic [2:0]          bit_cnt, bit_nxt;
  logic [7:0]          shreg, sh_nxt;
  logic                ook_nxt;
  logic [31:0]         freq_nxt;
  logic                done_nxt;
  logic                last;

  assign cfg_ready = (state == IDLE);
  assign tx_ready  = (state == IDLE) & ~cfg_valid;
  assign last      = (per_cnt == p_lat - ONE);

  always_comb begin
    state_nxt = state;
    per_nxt   = per_cnt;
    p_nxt     = p_lat;
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    ook_nxt   = ook_data;
    freq_nxt  = freq_word;
    unique case (state)
      IDLE: begin
        if (cfg_valid) begin
          freq_nxt = cfg_word;
        end else if (tx_valid) begin
          state_nxt = START;
          sh_nxt    = tx_data;
          p_nxt     = (bit_period == '0) ? ONE : bit_period;
          per_nxt   = '0;
          bit_nxt   = 3'd0;
          ook_nxt   = 1'b1;
        end
      end
      START: begin
        if (last) begin
          per_nxt   = '0;
          state_nxt = DATA;
          ook_nxt   = shreg[7];
        end else begin
          per_nxt = per_cnt + ONE;
        end
      end
      DATA: begin
        if (last) begin
          per_nxt = '0;
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
            ook_nxt   = 1'b0;
          end else begin
            // Next bit is the one that becomes MSB after this shift.
            bit_nxt = bit_cnt + 3'd1;
            sh_nxt  = {shreg[6:0], 1'b0};
            ook_nxt = shreg[6];
          end
        end else begin
          per_nxt = per_cnt + ONE;
        end
      end
      STOP: begin
        if (last) begin
          per_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          per_nxt = per_cnt + ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Registered pulse: high during the final STOP cycle.
    done_nxt = (state_nxt == STOP) && (per_nxt == p_nxt - ONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      per_cnt    <= '0;
      p_lat      <= ONE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      ook_data   <= 1'b0;
      freq_word  <= RESET_FREQ;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      per_cnt    <= per_nxt;
      p_lat      <= p_nxt;
      bit_cnt    <= bit_nxt;
      shreg      <= sh_nxt;
      ook_data   <= ook_nxt;
      freq_word  <= freq_nxt;
      busy       <= (state_nxt != IDLE);
      frame_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_dds_ook_ctrl.sv
// Directed bench for dds_ook_ctrl; per-cycle expected OOK/frame_done values are queued at stimulus time.
module tb_dds_ook_ctrl;

  localparam logic [31:0] RESET_FREQ = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_word = '0;
  logic        cfg_ready;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_ready;
  logic [15:0] bit_period = 16'd1;
  logic        ook_data;
  logic [31:0] freq_word;
  logic        busy;
  logic        frame_done;

  typedef struct packed {
    logic ook;
    logic done;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_freq = RESET_FREQ;

  always #5 clk = ~clk;

  dds_ook_ctrl #(.RESET_FREQ(RESET_FREQ), .PERIOD_W(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_word(cfg_word), .cfg_ready(cfg_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .bit_period(bit_period),
    .ook_data(ook_data), .freq_word(freq_word),
    .busy(busy), .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of cycle T+10P+1 (or after an abort).
  task automatic send(input logic [7:0] d, input logic [15:0] p_in, input int chg_cycle,
                      input logic [15:0] p_new, input bit mid_cfg, input int rst_at);
    int   pe;
    exp_t e;
    pe = (p_in == 16'd0) ? 1 : int'(p_in);
    tx_valid   = 1'b1;
    tx_data    = d;
    bit_period = p_in;
    #1;
    check("tx_ready_at_accept", tx_ready, 1);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 1; i <= 10 * pe; i++) begin
      e.ook  = (i <= pe) ? 1'b1 : (i > 9 * pe) ? 1'b0 : d[7 - (i - pe - 1) / pe];
      e.done = (i == 10 * pe);
      exp_q.push_back(e);
    end
    for (int i = 1; i <= 10 * pe; i++) begin
      e = exp_q.pop_front();
      check($sformatf("ook_c%0d", i), ook_data, e.ook);
      check($sformatf("done_c%0d", i), frame_done, e.done);
      check($sformatf("busy_c%0d", i), busy, 1);
      check($sformatf("freq_c%0d", i), freq_word, exp_freq);
      if (mid_cfg && i >= 3) check($sformatf("cfg_ready_c%0d", i), cfg_ready, 0);
      if (i == chg_cycle) bit_period = p_new;
      if (mid_cfg && i == 3) begin
        cfg_valid = 1'b1;
        cfg_word  = 32'h0300_0000;
      end
      if (i == rst_at) begin
        #2 rst = 1'b0;
        #1;
        check("rst_async_ook", ook_data, 0);
        check("rst_async_freq", freq_word, RESET_FREQ);
        check("rst_async_busy", busy, 0);
        exp_freq = RESET_FREQ;
        exp_q.delete();
        break;
      end
      @(negedge clk);
    end
    if (rst_at == 0) begin
      check("post_busy", busy, 0);
      check("post_ook", ook_data, 0);
      check("post_done", frame_done, 0);
      check("post_cfg_ready", cfg_ready, 1);
      check("post_tx_ready", tx_ready, mid_cfg ? 0 : 1);
      check("post_queue_empty", exp_q.size(), 0);
    end
  endtask

  initial begin
    // Reset with random inputs for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cfg_valid  = 1'($urandom_range(0, 1));
      cfg_word   = $urandom;
      tx_valid   = 1'($urandom_range(0, 1));
      tx_data    = 8'($urandom);
      bit_period = 16'($urandom_range(0, 7));
      #1;
      check("rst_freq", freq_word, RESET_FREQ);
      check("rst_ook", ook_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    tx_valid  = 1'b0;
    #1;
    check("rst_tx_ready", tx_ready, 1);
    check("rst_cfg_ready", cfg_ready, 1);
    rst = 1'b1;
    @(negedge clk);
    check("idle_freq", freq_word, RESET_FREQ);

    send(8'hA5, 16'd4, 0, 16'd0, 1'b0, 0);
    send(8'hFF, 16'd0, 0, 16'd0, 1'b0, 0);
    send(8'hFF, 16'd1, 0, 16'd0, 1'b0, 0);
    send(8'h5A, 16'd3, 5, 16'd10, 1'b0, 0);

    // Config and byte offered together: config first, byte next cycle.
    cfg_valid  = 1'b1;
    cfg_word   = 32'h0200_0000;
    tx_valid   = 1'b1;
    tx_data    = 8'h3C;
    bit_period = 16'd2;
    #1;
    check("both_tx_ready", tx_ready, 0);
    check("both_cfg_ready", cfg_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    exp_freq  = 32'h0200_0000;
    #1;
    check("both_freq", freq_word, exp_freq);
    check("both_not_busy", busy, 0);
    check("both_tx_ready_next", tx_ready, 1);
    send(8'h3C, 16'd2, 0, 16'd0, 1'b1, 0);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    exp_freq  = 32'h0300_0000;
    check("cfg_after_frame", freq_word, exp_freq);

    // Reset in DATA bit 3 (cycles 17..20 for P=4).
    send(8'hFF, 16'd4, 0, 16'd0, 1'b0, 18);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_hold_done", frame_done, 0);
      check("rst_hold_ook", ook_data, 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      check("abandon_no_done", frame_done, 0);
      check("abandon_ook", ook_data, 0);
    end
    check("abandon_freq", freq_word, RESET_FREQ);
    send(8'hC3, 16'd2, 0, 16'd0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
